// File: rtl/synth_pkg.sv
// synth_pkg
// Shared types and constants for the synth voice sequencer.
//   seq_state_t  : sequencer FSM state (IDLE / GATE / GAP)
//   OSC_W        : width of the oscillator divider count
//   step_entry_t : one pattern RAM entry, {rest, count}
package synth_pkg;

    localparam int OSC_W = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        GAP  = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic             rest;
        logic [OSC_W-1:0] count;
    } step_entry_t;

endpackage

// File: rtl/seq_timer.sv
// seq_timer
// Down-counter pair that times one sequencer step.
//   clk, arstn  : clock, asynchronous active-low reset
//   load        : start of a step, loads both counters
//   hold        : freezes both counters
//   period_m1   : step period minus 1 (cycles)
//   gate_m1     : gate-high length minus 1 (cycles); only meaningful when gate length >= 1
//   step_end    : high on the last cycle of the step
//   gate_end    : high on the last gate-high cycle of the step
module seq_timer #(
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          arstn,
    input  logic          load,
    input  logic          hold,
    input  logic [TW-1:0] period_m1,
    input  logic [TW-1:0] gate_m1,
    output logic          step_end,
    output logic          gate_end
);

    logic [TW-1:0] step_cnt;
    logic [TW-1:0] gate_cnt;

    // Both counters saturate at zero, so a strobe stays asserted until the
    // next load; the FSM only looks at them in the states where they matter.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            step_cnt <= '0;
            gate_cnt <= '0;
        end else if (load) begin
            step_cnt <= period_m1;
            gate_cnt <= gate_m1;
        end else if (!hold) begin
            if (step_cnt != '0) begin
                step_cnt <= step_cnt - TW'(1);
            end
            if (gate_cnt != '0) begin
                gate_cnt <= gate_cnt - TW'(1);
            end
        end
    end

    assign step_end = (step_cnt == '0);
    assign gate_end = (gate_cnt == '0);

endmodule

// File: rtl/step_sequencer.sv
// step_sequencer
// Autonomous note sequencer: steps through a pattern of oscillator divider
// values and generates the ADSR gate for the synth voice.
//   clk, arstn  : clock, asynchronous active-low reset
//   wr_en       : pattern write strobe
//   wr_addr     : step index to write
//   wr_data     : {rest, count[11:0]}
//   run         : level, high runs the sequencer
//   hold        : freezes counters/FSM/index and forces trig low
//   last_step   : final step index before wrapping to 0
//   tempo_div   : step period minus 1 (0 treated as 1)
//   gate_len    : gate-high cycles per step (clamped to period minus 1)
//   osc_count   : oscillator divider of the current step
//   trig        : ADSR gate level
//   step_idx    : current step index
//   step_pulse  : one-cycle strobe on the first cycle of each step
module step_sequencer
    import synth_pkg::*;
#(
    parameter int STEPS = 8,
    parameter int TW    = 16
) (
    input  logic                     clk,
    input  logic                     arstn,
    input  logic                     wr_en,
    input  logic [$clog2(STEPS)-1:0] wr_addr,
    input  logic [OSC_W:0]           wr_data,
    input  logic                     run,
    input  logic                     hold,
    input  logic [$clog2(STEPS)-1:0] last_step,
    input  logic [TW-1:0]            tempo_div,
    input  logic [TW-1:0]            gate_len,
    output logic [OSC_W-1:0]         osc_count,
    output logic                     trig,
    output logic [$clog2(STEPS)-1:0] step_idx,
    output logic                     step_pulse
);

    localparam int AW = $clog2(STEPS);

    seq_state_t    state_q;
    seq_state_t    state_d;
    logic          run_q;
    step_entry_t   ram [STEPS];

    logic          begin_step;
    logic [AW-1:0] next_idx;
    step_entry_t   entry;
    logic [TW-1:0] tempo_eff;
    logic [TW-1:0] gate_eff;
    logic [TW-1:0] gate_m1;
    logic          step_end;
    logic          gate_end;

    // Pattern RAM. A write landing on the same edge as a step start is not
    // seen by that step: the read below uses the pre-edge contents.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            for (int i = 0; i < STEPS; i++) begin
                ram[i] <= '0;
            end
        end else if (wr_en) begin
            ram[wr_addr] <= step_entry_t'(wr_data);
        end
    end

    // Step timing derived from the live configuration; it is only consumed
    // when a step starts, which is what makes tempo/gate changes take effect
    // at the next boundary. The gate is clamped to P-1 so the last cycle of
    // every step is low and the ADSR sees a fresh rising edge each step.
    always_comb begin
        tempo_eff = (tempo_div == '0) ? TW'(1) : tempo_div;
        gate_eff  = (gate_len < tempo_eff) ? gate_len : tempo_eff;
        gate_m1   = (gate_eff == '0) ? '0 : gate_eff - TW'(1);
    end

    // Next-state logic. run is registered once, so both start and stop act
    // one edge after run is sampled; a stop beats a simultaneous boundary.
    always_comb begin
        state_d    = state_q;
        begin_step = 1'b0;
        next_idx   = '0;
        if (state_q != IDLE && step_idx < last_step) begin
            next_idx = step_idx + AW'(1);
        end
        entry = ram[next_idx];

        if (!run_q) begin
            state_d = IDLE;
        end else if (!hold) begin
            unique case (state_q)
                IDLE: begin_step = 1'b1;
                GATE: begin
                    if (step_end) begin
                        begin_step = 1'b1;
                    end else if (gate_end) begin
                        state_d = GAP;
                    end
                end
                GAP: begin
                    if (step_end) begin
                        begin_step = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (begin_step) begin
                state_d = (entry.rest || gate_eff == '0) ? GAP : GATE;
            end
        end
    end

    seq_timer #(
        .TW(TW)
    ) u_timer (
        .clk       (clk),
        .arstn     (arstn),
        .load      (begin_step),
        .hold      (hold),
        .period_m1 (tempo_eff),
        .gate_m1   (gate_m1),
        .step_end  (step_end),
        .gate_end  (gate_end)
    );

    // State and registered outputs. osc_count only moves at step starts, so
    // it keeps the last played value through IDLE.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q    <= IDLE;
            run_q      <= 1'b0;
            osc_count  <= '0;
            trig       <= 1'b0;
            step_idx   <= '0;
            step_pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run;
            trig       <= (state_d == GATE) && !hold;
            step_pulse <= begin_step;
            if (state_d == IDLE) begin
                step_idx <= '0;
            end else if (begin_step) begin
                step_idx <= next_idx;
            end
            if (begin_step) begin
                osc_count <= entry.count;
            end
        end
    end

endmodule
